// File: rtl/tpgen_param.sv
// Parametrised timing-pulse generator: CLK_DIV phases per pulse, NUM_T one-hot pulses,
// restart forcing, monitor stop/step, sequence divider and sign-pair overflow strobe.
module tpgen_param #(
    parameter int NUM_T   = 12,
    parameter int CLK_DIV = 4,
    parameter int OVF_PH  = 2,
    parameter int TW      = $clog2(NUM_T + 1)
) (
    input  logic               SIM_CLK,
    input  logic               SIM_RST,
    input  logic               CLOCK_EN,
    input  logic               GOJ_REQ,
    input  logic               MSTP,
    input  logic               MSTRT,
    input  logic [1:0]         WL_SGN,
    output logic [CLK_DIV-1:0] PHS,
    output logic [NUM_T-1:0]   T,
    output logic [TW-1:0]      T_IDX,
    output logic               EOP,
    output logic               GOJAM,
    output logic               STOP,
    output logic               FS01,
    output logic               OVF_n,
    output logic               UNF_n
);

    localparam int PW = $clog2(CLK_DIV);

    generate
        if (NUM_T < 2 || CLK_DIV < 2 || OVF_PH >= CLK_DIV || OVF_PH < 0) begin : g_bad_params
            $error("tpgen_param: illegal NUM_T/CLK_DIV/OVF_PH combination");
        end
    endgenerate

    logic [PW-1:0] r_ph;
    logic [TW-1:0] r_tp;
    logic          r_gojam;
    logic          r_stop;
    logic          r_step_pend;
    logic          r_mstrt_d;
    logic          r_fs01;
    logic          r_ovf_n;
    logic          r_unf_n;
    logic          r_eop;

    logic w_last_ph;
    logic w_wrap;
    logic w_tp_last;
    logic w_mstrt_rise;
    logic w_strobe;

    assign w_last_ph    = (r_ph == PW'(CLK_DIV - 1));
    assign w_wrap       = CLOCK_EN & w_last_ph & ~GOJ_REQ;
    assign w_tp_last    = (r_tp == TW'(NUM_T));
    assign w_mstrt_rise = MSTRT & ~r_mstrt_d;
    assign w_strobe     = CLOCK_EN & (r_ph == PW'(OVF_PH)) & ~GOJ_REQ;

    always_ff @(posedge SIM_CLK or negedge SIM_RST) begin
        if (!SIM_RST) begin
            r_ph <= '0;
        end else if (GOJ_REQ) begin
            r_ph <= '0;
        end else if (CLOCK_EN) begin
            r_ph <= w_last_ph ? '0 : r_ph + PW'(1);
        end
    end

    // r_stop doubles as the hold flag: while set, the last pulse is repeated.
    always_ff @(posedge SIM_CLK or negedge SIM_RST) begin
        if (!SIM_RST) begin
            r_tp        <= TW'(NUM_T);
            r_gojam     <= 1'b1;
            r_stop      <= 1'b0;
            r_step_pend <= 1'b0;
            r_fs01      <= 1'b0;
        end else if (GOJ_REQ) begin
            r_tp        <= TW'(NUM_T);
            r_gojam     <= 1'b1;
            r_stop      <= 1'b0;
            r_step_pend <= 1'b0;
        end else begin
            if (w_mstrt_rise && r_stop) begin
                r_step_pend <= 1'b1;
            end
            if (w_wrap && w_tp_last) begin
                if (r_gojam) begin
                    // restart exit enters T01 without counting as a completed sequence
                    r_tp    <= TW'(1);
                    r_gojam <= 1'b0;
                end else if (r_stop) begin
                    if (r_step_pend || !MSTP) begin
                        r_tp        <= TW'(1);
                        r_stop      <= 1'b0;
                        r_step_pend <= 1'b0;
                        r_fs01      <= ~r_fs01;
                    end
                end else if (MSTP && !r_step_pend) begin
                    r_stop <= 1'b1;
                end else begin
                    r_tp   <= TW'(1);
                    r_fs01 <= ~r_fs01;
                end
            end else if (w_wrap) begin
                r_tp <= r_tp + TW'(1);
            end
        end
    end

    always_ff @(posedge SIM_CLK or negedge SIM_RST) begin
        if (!SIM_RST) begin
            r_mstrt_d <= 1'b0;
            r_eop     <= 1'b0;
        end else begin
            r_mstrt_d <= MSTRT;
            r_eop     <= CLOCK_EN & w_last_ph & ~GOJ_REQ;
        end
    end

    always_ff @(posedge SIM_CLK or negedge SIM_RST) begin
        if (!SIM_RST) begin
            r_ovf_n <= 1'b1;
            r_unf_n <= 1'b1;
        end else if (GOJ_REQ || r_gojam) begin
            r_ovf_n <= 1'b1;
            r_unf_n <= 1'b1;
        end else if (w_strobe) begin
            r_ovf_n <= ~(WL_SGN[0] & ~WL_SGN[1]);
            r_unf_n <= ~(~WL_SGN[0] & WL_SGN[1]);
        end
    end

    always_comb begin
        PHS = '0;
        for (int i = 0; i < CLK_DIV; i++) begin
            PHS[i] = (r_ph == PW'(i));
        end
    end

    always_comb begin
        T = '0;
        for (int i = 0; i < NUM_T; i++) begin
            T[i] = (r_tp == TW'(i + 1));
        end
    end

    assign T_IDX = r_tp;
    assign EOP   = r_eop;
    assign GOJAM = r_gojam;
    assign STOP  = r_stop;
    assign FS01  = r_fs01;
    assign OVF_n = r_ovf_n;
    assign UNF_n = r_unf_n;

endmodule

// File: tb/tb_tpgen_param.sv
// Directed bench for tpgen_param: default 12x4 instance plus a 5x8 instance with
// the overflow strobe on the last phase.
module tb_tpgen_param;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en, goj, mstp, mstrt;
    logic [1:0]  wl;
    logic [3:0]  phs;
    logic [11:0] t;
    logic [3:0]  t_idx;
    logic        eop, gojam, stop, fs01, ovf_n, unf_n;

    logic        rst2;
    logic        en2, goj2, mstp2, mstrt2;
    logic [1:0]  wl2;
    logic [7:0]  phs2;
    logic [4:0]  t2;
    logic [2:0]  t_idx2;
    logic        eop2, gojam2, stop2, fs012, ovf_n2, unf_n2;

    int vectors     = 0;
    int miscompares = 0;
    int eop_cnt;
    int exp_ph;

    always #5 clk = ~clk;

    tpgen_param u_dut (
        .SIM_CLK(clk), .SIM_RST(rst_n), .CLOCK_EN(en), .GOJ_REQ(goj), .MSTP(mstp),
        .MSTRT(mstrt), .WL_SGN(wl), .PHS(phs), .T(t), .T_IDX(t_idx), .EOP(eop),
        .GOJAM(gojam), .STOP(stop), .FS01(fs01), .OVF_n(ovf_n), .UNF_n(unf_n)
    );

    tpgen_param #(.NUM_T(5), .CLK_DIV(8), .OVF_PH(7)) u_dut2 (
        .SIM_CLK(clk), .SIM_RST(rst2), .CLOCK_EN(en2), .GOJ_REQ(goj2), .MSTP(mstp2),
        .MSTRT(mstrt2), .WL_SGN(wl2), .PHS(phs2), .T(t2), .T_IDX(t_idx2), .EOP(eop2),
        .GOJAM(gojam2), .STOP(stop2), .FS01(fs012), .OVF_n(ovf_n2), .UNF_n(unf_n2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b1; goj = 1'b0; mstp = 1'b0; mstrt = 1'b0; wl = 2'b00;
        rst2 = 1'b0; en2 = 1'b1; goj2 = 1'b0; mstp2 = 1'b0; mstrt2 = 1'b0; wl2 = 2'b01;

        // reset state
        tick(1);
        chk("rst_tidx", 32'(t_idx), 32'd12);
        chk("rst_t", 32'(t), 32'h800);
        chk("rst_phs", 32'(phs), 32'h1);
        chk("rst_gojam", 32'(gojam), 32'd1);
        chk("rst_stop", 32'(stop), 32'd0);
        chk("rst_fs01", 32'(fs01), 32'd0);
        chk("rst_ovf", 32'(ovf_n), 32'd1);
        chk("rst_unf", 32'(unf_n), 32'd1);
        chk("rst_eop", 32'(eop), 32'd0);
        rst_n = 1'b1;

        // restart exit and free run
        tick(3);
        chk("c3_tidx", 32'(t_idx), 32'd12);
        chk("c3_gojam", 32'(gojam), 32'd1);
        chk("c3_phs", 32'(phs), 32'h8);
        tick(1);
        chk("c4_tidx", 32'(t_idx), 32'd1);
        chk("c4_gojam", 32'(gojam), 32'd0);
        chk("c4_eop", 32'(eop), 32'd1);
        chk("c4_phs", 32'(phs), 32'h1);
        chk("c4_fs01", 32'(fs01), 32'd0);
        tick(4);
        chk("c8_t", 32'(t), 32'h002);
        tick(16);
        chk("c24_tidx", 32'(t_idx), 32'd6);
        tick(27);
        chk("c51_tidx", 32'(t_idx), 32'd12);
        chk("c51_fs01", 32'(fs01), 32'd0);
        tick(1);
        chk("c52_tidx", 32'(t_idx), 32'd1);
        chk("c52_fs01", 32'(fs01), 32'd1);

        // sign-pair strobe at phase 2
        wl = 2'b01;
        tick(3);
        chk("ovf01_ovf", 32'(ovf_n), 32'd0);
        chk("ovf01_unf", 32'(unf_n), 32'd1);
        wl = 2'b10;
        tick(1);
        chk("nostrobe_ovf", 32'(ovf_n), 32'd0);
        chk("nostrobe_unf", 32'(unf_n), 32'd1);
        tick(3);
        chk("unf10_ovf", 32'(ovf_n), 32'd1);
        chk("unf10_unf", 32'(unf_n), 32'd0);
        wl = 2'b11;
        tick(4);
        chk("s11_ovf", 32'(ovf_n), 32'd1);
        chk("s11_unf", 32'(unf_n), 32'd1);
        wl = 2'b01;
        tick(1);
        chk("nostrobe2_ovf", 32'(ovf_n), 32'd1);
        chk("c64_tidx", 32'(t_idx), 32'd4);

        // clock enable every third cycle
        eop_cnt = 0;
        exp_ph  = 0;
        for (int i = 0; i < 24; i++) begin
            en = (i % 3 == 0);
            tick(1);
            if (i % 3 == 0) exp_ph = (exp_ph + 1) % 4;
            chk("gated_phs", 32'(phs), 32'(1 << exp_ph));
            if (eop) eop_cnt++;
        end
        en = 1'b1;
        chk("gated_eop_cnt", 32'(eop_cnt), 32'd2);
        chk("gated_tidx", 32'(t_idx), 32'd6);
        chk("gated_ovf", 32'(ovf_n), 32'd0);

        // restart request during T06
        goj = 1'b1;
        tick(1);
        chk("goj_tidx", 32'(t_idx), 32'd12);
        chk("goj_phs", 32'(phs), 32'h1);
        chk("goj_gojam", 32'(gojam), 32'd1);
        chk("goj_ovf", 32'(ovf_n), 32'd1);
        tick(4);
        chk("goj_hold_phs", 32'(phs), 32'h1);
        chk("goj_hold_eop", 32'(eop), 32'd0);
        goj = 1'b0;
        tick(3);
        chk("gojx_tidx", 32'(t_idx), 32'd12);
        chk("gojx_gojam", 32'(gojam), 32'd1);
        tick(1);
        chk("gojx_t01", 32'(t_idx), 32'd1);
        chk("gojx_gojam0", 32'(gojam), 32'd0);
        chk("gojx_fs01", 32'(fs01), 32'd1);

        // monitor stop, single step, release
        tick(24);
        chk("t07_tidx", 32'(t_idx), 32'd7);
        mstp = 1'b1;
        tick(23);
        chk("prestop_stop", 32'(stop), 32'd0);
        tick(1);
        chk("stop_tidx", 32'(t_idx), 32'd12);
        chk("stop_stop", 32'(stop), 32'd1);
        chk("stop_eop", 32'(eop), 32'd1);
        tick(4);
        chk("held_tidx", 32'(t_idx), 32'd12);
        chk("held_eop", 32'(eop), 32'd1);
        mstrt = 1'b1;
        tick(3);
        chk("step_wait", 32'(t_idx), 32'd12);
        tick(1);
        chk("step_t01", 32'(t_idx), 32'd1);
        chk("step_stop", 32'(stop), 32'd0);
        mstrt = 1'b0;
        tick(20);
        mstrt = 1'b1;
        tick(24);
        chk("step_t12", 32'(t_idx), 32'd12);
        chk("step_t12_stop", 32'(stop), 32'd0);
        tick(4);
        chk("rehold_stop", 32'(stop), 32'd1);
        tick(8);
        chk("rehold_tidx", 32'(t_idx), 32'd12);
        mstp = 1'b0;
        tick(3);
        chk("rel_wait", 32'(stop), 32'd1);
        tick(1);
        chk("rel_t01", 32'(t_idx), 32'd1);
        chk("rel_stop", 32'(stop), 32'd0);
        tick(44);
        chk("free_t12", 32'(t_idx), 32'd12);
        tick(4);
        chk("free_t01", 32'(t_idx), 32'd1);

        // second instance: 5 pulses x 8 phases, strobe on phase 7
        rst2 = 1'b1;
        tick(7);
        chk("d2_c7_tidx", 32'(t_idx2), 32'd5);
        chk("d2_c7_gojam", 32'(gojam2), 32'd1);
        tick(1);
        chk("d2_c8_tidx", 32'(t_idx2), 32'd1);
        chk("d2_c8_t", 32'(t2), 32'h01);
        chk("d2_c8_gojam", 32'(gojam2), 32'd0);
        chk("d2_c8_eop", 32'(eop2), 32'd1);
        tick(7);
        chk("d2_c15_ovf", 32'(ovf_n2), 32'd1);
        tick(1);
        chk("d2_c16_ovf", 32'(ovf_n2), 32'd0);
        chk("d2_c16_unf", 32'(unf_n2), 32'd1);
        tick(31);
        chk("d2_c47_tidx", 32'(t_idx2), 32'd5);
        chk("d2_c47_fs01", 32'(fs012), 32'd0);
        tick(1);
        chk("d2_c48_tidx", 32'(t_idx2), 32'd1);
        chk("d2_c48_fs01", 32'(fs012), 32'd1);
        tick(18);
        chk("d2_t03", 32'(t_idx2), 32'd3);
        rst2 = 1'b0;
        #1;
        chk("d2_arst_tidx", 32'(t_idx2), 32'd5);
        chk("d2_arst_gojam", 32'(gojam2), 32'd1);
        chk("d2_arst_ovf", 32'(ovf_n2), 32'd1);
        chk("d2_arst_unf", 32'(unf_n2), 32'd1);
        chk("d2_arst_phs", 32'(phs2), 32'h01);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/tpgen_param.md
Name: tpgen_param

Overview:
Parametrised timing-pulse generator, the next generation of the fixed four-phase / twelve-pulse timer. It divides an enabled master clock into CLK_DIV phases per time pulse and sequences NUM_T one-hot time pulses. It provides restart (GOJAM) forcing, a monitor stop with single-step release, an end-of-pulse strobe, a sequence divider (FS01), and sign-pair overflow/underflow detection at a programmable phase. It feeds the control-pulse decoder and the sequence generator.

Parameters:
NUM_T, 12, time pulses per memory cycle (>=2)
CLK_DIV, 4, enabled clocks (phases) per time pulse (>=2)
OVF_PH, 2, phase index at which WL_SGN is strobed (0..CLK_DIV-1)
TW, $clog2(NUM_T+1), width of T_IDX

Ports:
SIM_CLK  in  1  system clock, all state on rising edge
SIM_RST  in  1  asynchronous, active-low reset
CLOCK_EN  in  1  master-oscillator enable; phase logic advances only when high
GOJ_REQ  in  1  restart request, level
MSTP  in  1  monitor stop request, level
MSTRT  in  1  monitor start/step, rising edge significant
WL_SGN  in  2  {WL16,WL15} sign pair of write bus
PHS  out  CLK_DIV  one-hot current phase
T  out  NUM_T  one-hot current time pulse, T[0]=T01
T_IDX  out  TW  current pulse number 1..NUM_T
EOP  out  1  one-cycle strobe on last enabled phase of each pulse
GOJAM  out  1  restart in progress
STOP  out  1  sequencer held at T_NUM_T
FS01  out  1  toggles once per complete sequence
OVF_n  out  1  low = positive overflow (WL15=1, WL16=0) at last strobe
UNF_n  out  1  low = negative overflow (WL15=0, WL16=1) at last strobe

Behaviour:
- All outputs registered or decoded from registers only. No combinational path from inputs to outputs.
- Reset (SIM_RST=0, async): ph=0, tp=NUM_T, GOJAM=1, STOP=0, FS01=0, OVF_n=1, UNF_n=1, step/edge regs=0. PHS=1, T=one-hot NUM_T.
- Wrap event W = CLOCK_EN & ph==CLK_DIV-1 & !GOJ_REQ. EOP = (ph==CLK_DIV-1) & CLOCK_EN, registered one cycle late to align with the ph->0 edge. EOP is suppressed while GOJ_REQ=1.
- Phase: on CLOCK_EN, ph<=(ph==CLK_DIV-1)?0:ph+1. CLOCK_EN low freezes ph, tp and strobes.
- Pulse advance on W, in priority order:
  - tp==NUM_T & hold -> stay at NUM_T.
  - tp==NUM_T -> tp=1 and FS01 toggles.
  - otherwise tp+1.
- GOJ_REQ=1, highest priority, next edge: tp=NUM_T, ph=0 and frozen, GOJAM=1, STOP=0, pending step cleared.
- After GOJ_REQ falls: one full T_NUM_T pulse (CLK_DIV enabled clocks) runs. At the W that enters T01, GOJAM<=0. If GOJ_REQ rises again mid-pulse, the sequence restarts as above.
- Stop and hold, decided at the W that ends T_NUM_T:
  - If MSTP=1 and no pending step: STOP<=1 and hold=1, so tp stays NUM_T. Phases keep running and EOP keeps pulsing.
- Step: MSTRT rising edge (registered edge detect) while STOP=1 sets step_pend.
  - At next W: tp->1, STOP<=0, step_pend<=0, and exactly one full sequence runs.
  - At its final W, STOP re-asserts if MSTP is still 1.
  - MSTRT edges while STOP=0 are ignored.
- MSTP falling while STOP=1: STOP<=0 at next W and tp->1. Free run resumes.
- Simultaneous MSTRT edge and MSTP fall resolve to the same result: one advance.
- Overflow strobe: on CLOCK_EN & ph==OVF_PH & !GOJ_REQ:
  - OVF_n <= !(WL15 & !WL16).
  - UNF_n <= !(!WL15 & WL16).
  - Both held between strobes. Both forced to 1 while GOJAM=1.
- Elaboration error if NUM_T<2, CLK_DIV<2, or OVF_PH>=CLK_DIV.

Test Plan:
- Reset release, GOJ_REQ=0, CLOCK_EN=1, defaults -> GOJAM=1 for cycles 0-3 with T_IDX=12, then T_IDX=1 at cycle 4 with GOJAM=0. Each pulse lasts 4 cycles; T_IDX returns to 1 at cycle 52 and FS01 toggles to 1 there.
- CLOCK_EN high every 3rd cycle -> each pulse lasts 12 clocks. EOP fires once per pulse. PHS stays one-hot and walks 0001->0010->0100->1000.
- GOJ_REQ pulsed 5 cycles during T_IDX=6 -> next edge gives T_IDX=12, PHS=0001, GOJAM=1. After release: 4 cycles of T12, then T01 with GOJAM=0.
- MSTP=1 set during T07 -> sequence holds at T_IDX=12 with STOP=1 and EOP still pulsing. One MSTRT rise -> exactly 12 pulses T01..T12 run, then hold again. MSTP=0 -> free run resumes at T01.
- WL_SGN=2'b01 at phase 2 -> OVF_n=0, UNF_n=1. Then 2'b10 -> OVF_n=1, UNF_n=0. Then 2'b11 -> both 1. WL_SGN changes at non-strobe phases -> no output change.
- NUM_T=5, CLK_DIV=8, OVF_PH=7 -> sequence period 40 enabled clocks, T_IDX max 5, strobe on last phase. Async SIM_RST mid-T03 -> immediate T_IDX=5, GOJAM=1, OVF_n=UNF_n=1.
